scene_sequencer: RTL

Frame-synchronous scene controller and pixel-source multiplexer between the game's pixel sources (start page, game renderer, end page, debug view) and vga_ctrl's pix_data input.
- Sequences the game flow START -> PLAY -> OVER/WON -> START.
- Commits scene changes only at frame boundaries, inserting black frames between scenes.
- Gates the game logic with run and reset pulses.
- Generalises the fixed single-source wiring: parametrised source count, colour width, hold times and auto-return.

---
 rtl/scene_sequencer_pkg.sv | 27 ++
 rtl/scene_sequencer_key_edge_sync.sv | 30 +++
 rtl/scene_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/scene_sequencer_pkg.sv
// Shared scene codes, pixel-source indices and sizing helpers for the scene sequencer.
package scene_sequencer_pkg;

  typedef enum logic [1:0] {
    SCN_START = 2'd0,
    SCN_PLAY  = 2'd1,
    SCN_OVER  = 2'd2,
    SCN_WON   = 2'd3
  } scene_e;

  localparam int unsigned SRC_START = 0;
  localparam int unsigned SRC_GAME  = 1;
  localparam int unsigned SRC_END   = 2;
  localparam int unsigned SRC_DEBUG = 3;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0..limit; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/scene_sequencer_key_edge_sync.sv
// Two-flop synchroniser for an asynchronous key level, followed by a registered rising-edge pulse.
module key_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= key_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/scene_sequencer.sv
// Frame-synchronous game-flow controller and pixel-source multiplexer feeding vga_ctrl.
module scene_sequencer
  import scene_sequencer_pkg::*;
#(
  parameter int unsigned RGB_W              = 16,
  parameter int unsigned NUM_SRC            = 4,
  parameter int unsigned BLANK_FRAMES       = 2,
  parameter int unsigned END_HOLD_FRAMES    = 180,
  parameter int unsigned AUTO_RETURN_FRAMES = 0
) (
  input  logic                       vga_clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       rgb_valid,
  input  logic                       key_any,
  input  logic                       game_over,
  input  logic                       game_won,
  input  logic                       debug_en,
  input  logic [NUM_SRC*RGB_W-1:0]   src_rgb,
  output logic [RGB_W-1:0]           out_rgb,
  output logic                       out_valid,
  output logic [$clog2(NUM_SRC)-1:0] sel,
  output logic [1:0]                 scene,
  output logic                       game_run,
  output logic                       game_reset
);

  localparam int unsigned SEL_W    = $clog2(NUM_SRC);
  localparam int unsigned HOLD_MAX = max_u(END_HOLD_FRAMES, AUTO_RETURN_FRAMES);
  localparam int unsigned HOLD_W   = cnt_w(HOLD_MAX);
  localparam int unsigned BLANK_W  = cnt_w(BLANK_FRAMES);
  localparam bit          HAS_DBG  = (NUM_SRC >= 4);
  localparam bit          AUTO_EN  = (AUTO_RETURN_FRAMES != 0);

  scene_e             scene_q, scene_d;
  scene_e             pend_scn_q, pend_scn_d;
  logic               pend_q, pend_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [RGB_W-1:0]   out_rgb_q, out_rgb_d;
  logic               out_valid_q;
  logic               game_run_q, game_run_d;
  logic               game_reset_q, game_reset_d;

  logic               key_rise;
  logic               req;
  scene_e             req_scn;
  logic               commit;
  logic               in_end;
  logic [SEL_W-1:0]   sel_c;
  logic [RGB_W-1:0]   src_arr [NUM_SRC];

  key_edge_sync u_key_sync (
    .clk    (vga_clk),
    .reset  (reset),
    .key_i  (key_any),
    .rise_o (key_rise)
  );

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign src_arr[k] = src_rgb[k*RGB_W +: RGB_W];
  end

  // Source select follows debug_en immediately; only the scene is frame-aligned.
  always_comb begin
    sel_c = SEL_W'(SRC_START);
    case (scene_q)
      SCN_PLAY: sel_c = (HAS_DBG && debug_en) ? SEL_W'(SRC_DEBUG) : SEL_W'(SRC_GAME);
      SCN_OVER,
      SCN_WON:  sel_c = SEL_W'(SRC_END);
      default:  sel_c = SEL_W'(SRC_START);
    endcase
  end

  always_comb begin
    scene_d      = scene_q;
    pend_d       = pend_q;
    pend_scn_d   = pend_scn_q;
    blank_d      = blank_q;
    hold_d       = hold_q;
    game_reset_d = 1'b0;
    req          = 1'b0;
    req_scn      = SCN_START;
    in_end       = (scene_q == SCN_OVER) || (scene_q == SCN_WON);
    commit       = frame_start && pend_q;

    case (scene_q)
      SCN_START: begin
        if (key_rise) begin
          req     = 1'b1;
          req_scn = SCN_PLAY;
        end
      end
      SCN_PLAY: begin
        if (game_won) begin
          req     = 1'b1;
          req_scn = SCN_WON;
        end else if (game_over) begin
          req     = 1'b1;
          req_scn = SCN_OVER;
        end
      end
      default: begin
        if ((key_rise && (hold_q >= HOLD_W'(END_HOLD_FRAMES))) ||
            (AUTO_EN && (hold_q == HOLD_W'(AUTO_RETURN_FRAMES)))) begin
          req     = 1'b1;
          req_scn = SCN_START;
        end
      end
    endcase

    // A committing frame_start reloads the counters instead of advancing them.
    if (commit) begin
      scene_d      = pend_scn_q;
      pend_d       = 1'b0;
      blank_d      = BLANK_W'(BLANK_FRAMES);
      hold_d       = '0;
      game_reset_d = (pend_scn_q == SCN_PLAY);
    end else begin
      if (!pend_q && req) begin
        pend_d     = 1'b1;
        pend_scn_d = req_scn;
      end
      if (frame_start && (blank_q != '0)) begin
        blank_d = blank_q - BLANK_W'(1);
      end
      if (frame_start && in_end && (hold_q != HOLD_W'(HOLD_MAX))) begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end

    game_run_d = (scene_d == SCN_PLAY) && (blank_d == '0) && !pend_d;
    out_rgb_d  = (rgb_valid && (blank_q == '0)) ? src_arr[sel_c] : RGB_W'(RGB565_BLACK);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      scene_q      <= SCN_START;
      pend_scn_q   <= SCN_START;
      pend_q       <= 1'b0;
      blank_q      <= '0;
      hold_q       <= '0;
      out_rgb_q    <= '0;
      out_valid_q  <= 1'b0;
      game_run_q   <= 1'b0;
      game_reset_q <= 1'b0;
    end else begin
      scene_q      <= scene_d;
      pend_scn_q   <= pend_scn_d;
      pend_q       <= pend_d;
      blank_q      <= blank_d;
      hold_q       <= hold_d;
      out_rgb_q    <= out_rgb_d;
      out_valid_q  <= rgb_valid;
      game_run_q   <= game_run_d;
      game_reset_q <= game_reset_d;
    end
  end

  assign out_rgb    = out_rgb_q;
  assign out_valid  = out_valid_q;
  assign sel        = sel_c;
  assign scene      = scene_q;
  assign game_run   = game_run_q;
  assign game_reset = game_reset_q;

endmodule
